// File: rtl/mips_cpu_regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Provides load opcodes, the writeback request record and a register one-hot helper.
package mips_cpu_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LWR = 6'b100110;

    // "reg" is a keyword, so the destination field is named wreg
    typedef struct packed {
        logic [4:0]  wreg;
        logic [31:0] data;
        logic [5:0]  opcode;
        logic [1:0]  vaddr;
    } wb_req_t;

    function automatic logic [31:0] reg_onehot(input logic [4:0] r);
        return 32'd1 << r;
    endfunction

endpackage

// File: rtl/mips_cpu_regfile_wb_arbiter_if.sv
// Bundle of ALU writeback, load issue/response, hazard query and register-file write signals.
// master = pipeline side driving requests, slave = the arbiter.
interface mips_cpu_regfile_wb_arbiter_if;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_reg;
    logic [31:0] alu_wb_data;
    logic [5:0]  alu_wb_opcode;
    logic        alu_wb_ready;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_reg;
    logic        ld_rsp_valid;
    logic        ld_rsp_ready;
    logic [4:0]  ld_rsp_reg;
    logic [31:0] ld_rsp_data;
    logic [5:0]  ld_rsp_opcode;
    logic [1:0]  ld_rsp_vaddr;
    logic [4:0]  rd_reg1;
    logic [4:0]  rd_reg2;
    logic [4:0]  chk_wreg;
    logic        hazard_stall;
    logic        rf_regwrite;
    logic [4:0]  rf_writereg;
    logic [31:0] rf_writedata;
    logic [5:0]  rf_opcode;
    logic [1:0]  rf_vaddr;

    modport master (
        output alu_wb_valid, alu_wb_reg, alu_wb_data, alu_wb_opcode,
        output ld_issue_valid, ld_issue_reg,
        output ld_rsp_valid, ld_rsp_reg, ld_rsp_data, ld_rsp_opcode, ld_rsp_vaddr,
        output rd_reg1, rd_reg2, chk_wreg,
        input  alu_wb_ready, ld_rsp_ready, hazard_stall,
        input  rf_regwrite, rf_writereg, rf_writedata, rf_opcode, rf_vaddr
    );

    modport slave (
        input  alu_wb_valid, alu_wb_reg, alu_wb_data, alu_wb_opcode,
        input  ld_issue_valid, ld_issue_reg,
        input  ld_rsp_valid, ld_rsp_reg, ld_rsp_data, ld_rsp_opcode, ld_rsp_vaddr,
        input  rd_reg1, rd_reg2, chk_wreg,
        output alu_wb_ready, ld_rsp_ready, hazard_stall,
        output rf_regwrite, rf_writereg, rf_writedata, rf_opcode, rf_vaddr
    );
endinterface

// File: rtl/mips_cpu_regfile_wb_arbiter_fifo.sv
// Synchronous FIFO of writeback requests with full/empty flags (DEPTH must be a power of two).
// Pushes while full and pops while empty are ignored.
module mips_cpu_wb_fifo
    import mips_cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_push,
    input  wb_req_t i_data,
    input  logic    i_pop,
    output wb_req_t o_head,
    output logic    o_full,
    output logic    o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t        r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == (AW+1)'(0));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/mips_cpu_regfile_wb_arbiter.sv
// Arbitrates the register-file write port between ALU writeback and queued load responses,
// and tracks pending loads for RAW/WAW stalls. Optional counters: define REGFILE_WB_STATS_EN.
module mips_cpu_regfile_wb_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int LOAD_Q_DEPTH = 2,
    parameter int MAX_WAIT     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    mips_cpu_regfile_wb_arbiter_if.slave  wb
`ifdef REGFILE_WB_STATS_EN
    ,
    output logic [31:0]                   stat_alu_wr,
    output logic [31:0]                   stat_ld_wr,
    output logic [31:0]                   stat_stall
`endif
);
    localparam int SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

    wb_req_t      w_push_data;
    wb_req_t      w_head;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic         w_grant_ld;
    logic         w_grant_alu;
    logic         w_issue_match;
    logic [31:0]  w_pending_next;
    logic [SW-1:0] r_starve;
    logic [31:0]  r_pending;
    logic         r_regwrite;
    logic [4:0]   r_writereg;
    logic [31:0]  r_writedata;
    logic [5:0]   r_opcode;
    logic [1:0]   r_vaddr;

    assign w_push_data.wreg   = wb.ld_rsp_reg;
    assign w_push_data.data   = wb.ld_rsp_data;
    assign w_push_data.opcode = wb.ld_rsp_opcode;
    assign w_push_data.vaddr  = wb.ld_rsp_vaddr;

    mips_cpu_wb_fifo #(
        .DEPTH (LOAD_Q_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (wb.ld_rsp_valid),
        .i_data  (w_push_data),
        .i_pop   (w_grant_ld),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Load wins when the ALU is idle, the queue is full, or the head has waited MAX_WAIT cycles
    always_comb begin
        w_grant_ld  = 1'b0;
        w_grant_alu = 1'b0;
        if (!w_fifo_empty) begin
            w_grant_ld = !wb.alu_wb_valid || w_fifo_full || (r_starve == STARVE_MAX);
        end else begin
            w_grant_ld = 1'b0;
        end
        w_grant_alu = wb.alu_wb_valid && !w_grant_ld;
    end

    assign wb.alu_wb_ready = !w_grant_ld;
    assign wb.ld_rsp_ready = !w_fifo_full;

    // Starvation counter for the FIFO head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_grant_ld || w_fifo_empty) begin
            r_starve <= '0;
        end else if (w_grant_alu && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Registered write port; fields hold when nothing is granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwrite  <= 1'b0;
            r_writereg  <= 5'd0;
            r_writedata <= 32'd0;
            r_opcode    <= 6'd0;
            r_vaddr     <= 2'd0;
        end else if (w_grant_ld) begin
            r_regwrite  <= 1'b1;
            r_writereg  <= w_head.wreg;
            r_writedata <= w_head.data;
            r_opcode    <= w_head.opcode;
            r_vaddr     <= w_head.vaddr;
        end else if (w_grant_alu) begin
            r_regwrite  <= 1'b1;
            r_writereg  <= wb.alu_wb_reg;
            r_writedata <= wb.alu_wb_data;
            r_opcode    <= wb.alu_wb_opcode;
            r_vaddr     <= 2'd0;
        end else begin
            r_regwrite  <= 1'b0;
        end
    end

    assign wb.rf_regwrite  = r_regwrite;
    assign wb.rf_writereg  = r_writereg;
    assign wb.rf_writedata = r_writedata;
    assign wb.rf_opcode    = r_opcode;
    assign wb.rf_vaddr     = r_vaddr;

    // Set is applied after clear so a same-cycle reissue keeps the register pending
    always_comb begin
        w_pending_next = (r_pending & ~(w_grant_ld ? reg_onehot(w_head.wreg) : 32'd0))
                       | (wb.ld_issue_valid ? reg_onehot(wb.ld_issue_reg) : 32'd0);
        w_pending_next[0] = 1'b0;
    end

    // Pending-load scoreboard
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign w_issue_match = wb.ld_issue_valid && (wb.ld_issue_reg != 5'd0) &&
                           ((wb.ld_issue_reg == wb.rd_reg1) ||
                            (wb.ld_issue_reg == wb.rd_reg2) ||
                            (wb.ld_issue_reg == wb.chk_wreg));

    assign wb.hazard_stall = r_pending[wb.rd_reg1] | r_pending[wb.rd_reg2] |
                             r_pending[wb.chk_wreg] | w_issue_match;

`ifdef REGFILE_WB_STATS_EN
    // Free-running activity counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_alu_wr <= 32'd0;
            stat_ld_wr  <= 32'd0;
            stat_stall  <= 32'd0;
        end else begin
            if (w_grant_alu)     stat_alu_wr <= stat_alu_wr + 32'd1;
            if (w_grant_ld)      stat_ld_wr  <= stat_ld_wr + 32'd1;
            if (wb.hazard_stall) stat_stall  <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_cpu_regfile_wb_arbiter.sv
// Directed and randomized bench for the writeback arbiter with a queue-based reference model.
module tb_mips_cpu_regfile_wb_arbiter;
    import mips_cpu_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXW  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_cpu_regfile_wb_arbiter_if bus();

`ifdef REGFILE_WB_STATS_EN
    logic [31:0] stat_alu_wr, stat_ld_wr, stat_stall;
`endif

    mips_cpu_regfile_wb_arbiter #(
        .LOAD_Q_DEPTH (DEPTH),
        .MAX_WAIT     (MAXW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (bus)
`ifdef REGFILE_WB_STATS_EN
        ,
        .stat_alu_wr (stat_alu_wr),
        .stat_ld_wr  (stat_ld_wr),
        .stat_stall  (stat_stall)
`endif
    );

    int checks = 0;
    int failures = 0;

    wb_req_t     m_q[$];
    int          m_starve;
    bit [31:0]   m_pend;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [5:0]  e_op;
    logic [1:0]  e_va;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_starve = 0;
        m_pend = '0;
        e_we = 1'b0; e_reg = 5'd0; e_data = 32'd0; e_op = 6'd0; e_va = 2'd0;
    endtask

    task automatic idle();
        bus.alu_wb_valid = 1'b0; bus.alu_wb_reg = 5'd0; bus.alu_wb_data = 32'd0; bus.alu_wb_opcode = 6'd0;
        bus.ld_issue_valid = 1'b0; bus.ld_issue_reg = 5'd0;
        bus.ld_rsp_valid = 1'b0; bus.ld_rsp_reg = 5'd0; bus.ld_rsp_data = 32'd0;
        bus.ld_rsp_opcode = 6'd0; bus.ld_rsp_vaddr = 2'd0;
        bus.rd_reg1 = 5'd0; bus.rd_reg2 = 5'd0; bus.chk_wreg = 5'd0;
    endtask

    // One clock: check combinational outputs, advance the model at posedge, check the write port.
    task automatic step(input string tag);
        bit full, empty, gl, ga, stall;
        wb_req_t h, n;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        gl = !empty && (!bus.alu_wb_valid || full || (m_starve == MAXW));
        ga = bus.alu_wb_valid && !gl;
        stall = m_pend[bus.rd_reg1] || m_pend[bus.rd_reg2] || m_pend[bus.chk_wreg] ||
                (bus.ld_issue_valid && bus.ld_issue_reg != 5'd0 &&
                 (bus.ld_issue_reg == bus.rd_reg1 || bus.ld_issue_reg == bus.rd_reg2 ||
                  bus.ld_issue_reg == bus.chk_wreg));
        #1;
        chk({tag, ".alu_ready"}, bus.alu_wb_ready, !gl);
        chk({tag, ".ld_rsp_ready"}, bus.ld_rsp_ready, !full);
        chk({tag, ".hazard_stall"}, bus.hazard_stall, stall);
        @(posedge clk);
        if (gl) begin
            h = m_q.pop_front();
            e_we = 1'b1; e_reg = h.wreg; e_data = h.data; e_op = h.opcode; e_va = h.vaddr;
            m_pend[h.wreg] = 1'b0;
        end else if (ga) begin
            e_we = 1'b1; e_reg = bus.alu_wb_reg; e_data = bus.alu_wb_data;
            e_op = bus.alu_wb_opcode; e_va = 2'd0;
        end else begin
            e_we = 1'b0;
        end
        if (gl || empty) m_starve = 0;
        else if (ga && m_starve < MAXW) m_starve++;
        if (bus.ld_rsp_valid && !full) begin
            n.wreg = bus.ld_rsp_reg; n.data = bus.ld_rsp_data;
            n.opcode = bus.ld_rsp_opcode; n.vaddr = bus.ld_rsp_vaddr;
            m_q.push_back(n);
        end
        if (bus.ld_issue_valid) m_pend[bus.ld_issue_reg] = 1'b1;
        m_pend[0] = 1'b0;
        #1;
        chk({tag, ".rf_regwrite"}, bus.rf_regwrite, e_we);
        chk({tag, ".rf_writereg"}, bus.rf_writereg, e_reg);
        chk({tag, ".rf_writedata"}, bus.rf_writedata, e_data);
        chk({tag, ".rf_opcode"}, bus.rf_opcode, e_op);
        chk({tag, ".rf_vaddr"}, bus.rf_vaddr, e_va);
        @(negedge clk);
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset.rf_regwrite", bus.rf_regwrite, 1'b0);
        chk("reset.rf_writereg", bus.rf_writereg, 5'd0);
        chk("reset.rf_writedata", bus.rf_writedata, 32'd0);
        chk("reset.rf_opcode", bus.rf_opcode, 6'd0);
        chk("reset.rf_vaddr", bus.rf_vaddr, 2'd0);
        chk("reset.ld_rsp_ready", bus.ld_rsp_ready, 1'b1);
        chk("reset.alu_ready", bus.alu_wb_ready, 1'b1);
        chk("reset.hazard_stall", bus.hazard_stall, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // ALU-only write
        bus.alu_wb_valid = 1'b1; bus.alu_wb_reg = 5'd5; bus.alu_wb_data = 32'h1234; bus.alu_wb_opcode = 6'd0;
        step("alu");
        chk("alu.we_const", bus.rf_regwrite, 1'b1);
        chk("alu.reg_const", bus.rf_writereg, 5'd5);
        chk("alu.data_const", bus.rf_writedata, 32'h1234);
        chk("alu.vaddr_const", bus.rf_vaddr, 2'd0);
        idle();

        // Starvation: one queued load behind a continuous ALU stream
        bus.alu_wb_valid = 1'b1; bus.alu_wb_reg = 5'd1; bus.alu_wb_data = 32'h11;
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_reg = 5'd7; bus.ld_rsp_data = 32'hAABBCCDD;
        bus.ld_rsp_opcode = OP_LB; bus.ld_rsp_vaddr = 2'd2;
        step("st_push");
        bus.ld_rsp_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.alu_wb_data = 32'(i);
            step("st_alu");
            chk("st_alu.reg_const", bus.rf_writereg, 5'd1);
        end
        #1;
        chk("st4.alu_ready_const", bus.alu_wb_ready, 1'b0);
        step("st4");
        chk("st4.reg_const", bus.rf_writereg, 5'd7);
        chk("st4.data_const", bus.rf_writedata, 32'hAABBCCDD);
        chk("st4.op_const", bus.rf_opcode, OP_LB);
        chk("st4.vaddr_const", bus.rf_vaddr, 2'd2);
        idle();

        // Full FIFO forces a load despite ALU valid; order preserved
        bus.alu_wb_valid = 1'b1; bus.alu_wb_reg = 5'd2; bus.alu_wb_data = 32'h22;
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_reg = 5'd10; bus.ld_rsp_data = 32'hD0D0D0D0; bus.ld_rsp_opcode = OP_LH;
        step("full_push0");
        bus.ld_rsp_reg = 5'd11; bus.ld_rsp_data = 32'hD1D1D1D1; bus.ld_rsp_opcode = OP_LWL; bus.ld_rsp_vaddr = 2'd1;
        step("full_push1");
        bus.ld_rsp_reg = 5'd12; bus.ld_rsp_data = 32'hDEADBEEF;
        #1;
        chk("full.ld_rsp_ready_const", bus.ld_rsp_ready, 1'b0);
        step("full_force");
        chk("full_force.reg_const", bus.rf_writereg, 5'd10);
        bus.ld_rsp_valid = 1'b0; bus.alu_wb_valid = 1'b0;
        step("full_second");
        chk("full_second.data_const", bus.rf_writedata, 32'hD1D1D1D1);
        idle();

        // Scoreboard: issue reg 9, stall until its grant
        bus.ld_issue_valid = 1'b1; bus.ld_issue_reg = 5'd9; bus.rd_reg1 = 5'd9;
        #1;
        chk("sb.bypass_const", bus.hazard_stall, 1'b1);
        step("sb_issue");
        bus.ld_issue_valid = 1'b0;
        step("sb_wait");
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_reg = 5'd9; bus.ld_rsp_data = 32'h99;
        step("sb_push");
        bus.ld_rsp_valid = 1'b0;
        #1;
        chk("sb.grant_cycle_const", bus.hazard_stall, 1'b1);
        step("sb_grant");
        #1;
        chk("sb.cleared_const", bus.hazard_stall, 1'b0);
        bus.rd_reg1 = 5'd0; bus.ld_issue_valid = 1'b1; bus.ld_issue_reg = 5'd0;
        step("sb_r0");
        idle();

        // Same-cycle set and clear of register 4
        bus.ld_issue_valid = 1'b1; bus.ld_issue_reg = 5'd4;
        step("sc_issue");
        bus.ld_issue_valid = 1'b0;
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_reg = 5'd4; bus.ld_rsp_data = 32'h44;
        step("sc_push");
        bus.ld_rsp_valid = 1'b0; bus.ld_issue_valid = 1'b1; bus.ld_issue_reg = 5'd4;
        step("sc_setclr");
        bus.ld_issue_valid = 1'b0; bus.rd_reg1 = 5'd4;
        #1;
        chk("sc.still_pending_const", bus.hazard_stall, 1'b1);
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 32'h45;
        step("sc_push2");
        bus.ld_rsp_valid = 1'b0;
        step("sc_grant2");
        #1;
        chk("sc.cleared_const", bus.hazard_stall, 1'b0);
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.alu_wb_valid   = 1'($urandom_range(0, 1));
            bus.alu_wb_reg     = 5'($urandom);
            bus.alu_wb_data    = $urandom;
            bus.alu_wb_opcode  = 6'($urandom);
            bus.ld_issue_valid = ($urandom_range(0, 3) == 0);
            bus.ld_issue_reg   = 5'($urandom);
            bus.ld_rsp_valid   = 1'($urandom_range(0, 1));
            bus.ld_rsp_reg     = 5'($urandom);
            bus.ld_rsp_data    = $urandom;
            bus.ld_rsp_opcode  = 6'($urandom);
            bus.ld_rsp_vaddr   = 2'($urandom);
            bus.rd_reg1        = 5'($urandom);
            bus.rd_reg2        = 5'($urandom);
            bus.chk_wreg       = 5'($urandom);
            step("rnd");
        end
        idle();

        // Reset mid-run with two queued loads and a pending register
        bus.alu_wb_valid = 1'b1; bus.alu_wb_reg = 5'd3; bus.alu_wb_data = 32'h33;
        step("rr_drain0");
        step("rr_drain1");
        step("rr_drain2");
        bus.ld_issue_valid = 1'b1; bus.ld_issue_reg = 5'd13;
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_reg = 5'd20; bus.ld_rsp_data = 32'h2020;
        step("rr_push0");
        bus.ld_issue_valid = 1'b0;
        bus.ld_rsp_reg = 5'd21; bus.ld_rsp_data = 32'h2121;
        step("rr_push1");
        rst = 1'b0;
        model_reset();
        #1;
        chk("rr.rf_regwrite_const", bus.rf_regwrite, 1'b0);
        chk("rr.ld_rsp_ready_const", bus.ld_rsp_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("rr.held_regwrite_const", bus.rf_regwrite, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        bus.rd_reg1 = 5'd13;
        step("rr_post0");
        chk("rr_post0.stall_const", bus.hazard_stall, 1'b0);
        step("rr_post1");
        chk("rr_post1.we_const", bus.rf_regwrite, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
